// File: rtl/issue_select_pkg.sv
// Shared types and sizes for the issue-select stage.
// The optional performance counters are enabled with the ISSUE_SELECT_PERF_EN macro.
package issue_select_pkg;

    localparam int RS_ENTRIES = 16;
    localparam int NUM_FUS    = 4;
    localparam int IDX_W      = $clog2(RS_ENTRIES);
    localparam int FU_W       = $clog2(NUM_FUS);

    typedef logic [IDX_W-1:0] rs_idx_t;
    typedef logic [FU_W-1:0]  fu_type_t;

    typedef struct packed {
        logic    valid;
        rs_idx_t idx;
    } issue_slot_t;

    // Encode a one-hot (or empty) row vector into a row index.
    function automatic rs_idx_t onehot_to_idx(input logic [RS_ENTRIES-1:0] oh);
        rs_idx_t idx;
        idx = '0;
        for (int j = 0; j < RS_ENTRIES; j++) begin
            if (oh[j]) idx = idx | rs_idx_t'(j);
        end
        return idx;
    endfunction

endpackage

// File: rtl/issue_select_age_matrix.sv
// Age matrix for the reservation station: age_q[i][j]=1 means row j is older than row i.
// One shared matrix; the oldest-candidate function is evaluated per FU candidate vector.
module issue_select_age_matrix
    import issue_select_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc_en_i,
    input  rs_idx_t                            alloc_idx_i,
    input  logic [RS_ENTRIES-1:0]              alloc_row_i,
    input  logic [RS_ENTRIES-1:0]              clear_rows_i,
    input  logic [NUM_FUS-1:0][RS_ENTRIES-1:0] cand_i,
    output logic [NUM_FUS-1:0][RS_ENTRIES-1:0] oldest_o
);

    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age_q, age_d;

    // Next matrix: retired rows drop their bits; a new row sees every live row as older
    // and is itself younger than everyone (its column is cleared).
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (clear_rows_i[i]) age_d[i] = '0;
        end
        if (alloc_en_i) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                age_d[i][alloc_idx_i] = 1'b0;
            end
            age_d[alloc_idx_i]              = alloc_row_i;
            age_d[alloc_idx_i][alloc_idx_i] = 1'b0;
        end
    end

    // Matrix register.
    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end

    // A candidate wins when no other candidate of the same vector is older than it.
    always_comb begin
        oldest_o = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                oldest_o[f][i] = cand_i[f][i] & ~|(age_q[i] & cand_i[f]);
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Oldest-first issue select: one grant per FU per cycle into a registered issue slot,
// with selected/clear feedback to wakeup and freed rows to the free-entry queue.
// Optional perf counters (perf_issue_cnt/perf_stall_cnt) under ISSUE_SELECT_PERF_EN.
// Handshake: a slot is offered while issue_valid[f]=1 and is consumed on a cycle where
// issue_ready[f]=1; issue_valid/issue_idx never change while issue_valid=1 and issue_ready=0.
module issue_select
    import issue_select_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           alloc_en,
    input  logic [IDX_W-1:0]               alloc_idx,
    input  logic [FU_W-1:0]                alloc_fu,
    input  logic [RS_ENTRIES-1:0]          request_vec,
    output logic [NUM_FUS-1:0]             issue_valid,
    output logic [NUM_FUS*IDX_W-1:0]       issue_idx,
    input  logic [NUM_FUS-1:0]             issue_ready,
    output logic [RS_ENTRIES-1:0]          selected_vec,
    output logic                           clear_en,
    output logic [RS_ENTRIES*NUM_FUS-1:0]  clear_lines,
    output logic [RS_ENTRIES-1:0]          free_vec
`ifdef ISSUE_SELECT_PERF_EN
    ,
    output logic [NUM_FUS*32-1:0]          perf_issue_cnt,
    output logic [NUM_FUS*32-1:0]          perf_stall_cnt
`endif
);

    logic [RS_ENTRIES-1:0]              valid_q, valid_d;
    fu_type_t                           fu_q [RS_ENTRIES];
    fu_type_t                           fu_d [RS_ENTRIES];
    issue_slot_t                        slot_q [NUM_FUS];
    issue_slot_t                        slot_d [NUM_FUS];
    logic [RS_ENTRIES-1:0]              selected_q, selected_d;
    logic [RS_ENTRIES-1:0]              free_q, free_d;
    logic [RS_ENTRIES*NUM_FUS-1:0]      clear_q, clear_d;
    logic                               clear_en_q, clear_en_d;
    logic [NUM_FUS-1:0][RS_ENTRIES-1:0] cand, oldest, grant;
    logic [NUM_FUS-1:0]                 slot_free;
    logic [RS_ENTRIES-1:0]              grant_rows;
    logic                               alloc_ok;

    // Per-FU candidate vectors: requesting, live, and of that FU type.
    always_comb begin
        cand = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                cand[f][j] = request_vec[j] & valid_q[j] & (fu_q[j] == fu_type_t'(f));
            end
        end
    end

    // A re-allocation of a live row is dropped; flush outranks allocation.
    assign alloc_ok = alloc_en & ~flush & ~valid_q[alloc_idx];

    issue_select_age_matrix u_age (
        .clk          (clk),
        .rst          (rst),
        .alloc_en_i   (alloc_ok),
        .alloc_idx_i  (alloc_idx),
        .alloc_row_i  (valid_q),
        .clear_rows_i (flush ? {RS_ENTRIES{1'b1}} : grant_rows),
        .cand_i       (cand),
        .oldest_o     (oldest)
    );

    // Grants: a winner is taken only into a free slot, and never during a flush.
    always_comb begin
        slot_free  = '0;
        grant      = '0;
        grant_rows = '0;
        clear_d    = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            slot_free[f] = ~slot_q[f].valid | issue_ready[f];
            if (slot_free[f] && !flush) grant[f] = oldest[f];
            grant_rows = grant_rows | grant[f];
            clear_d[f*RS_ENTRIES +: RS_ENTRIES] = grant[f];
        end
    end

    // Next entry state, slot contents and one-cycle feedback pulses.
    always_comb begin
        valid_d = valid_q & ~grant_rows;
        fu_d    = fu_q;
        if (alloc_ok) begin
            valid_d[alloc_idx] = 1'b1;
            fu_d[alloc_idx]    = alloc_fu;
        end
        if (flush) valid_d = '0;

        for (int f = 0; f < NUM_FUS; f++) begin
            slot_d[f] = slot_q[f];
            if (flush) begin
                slot_d[f].valid = 1'b0;
            end else if (slot_free[f]) begin
                slot_d[f].valid = |grant[f];
                if (|grant[f]) slot_d[f].idx = onehot_to_idx(grant[f]);
            end
        end

        selected_d = grant_rows;
        free_d     = flush ? valid_q : grant_rows;
        clear_en_d = |grant_rows;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            selected_q <= '0;
            free_q     <= '0;
            clear_q    <= '0;
            clear_en_q <= 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) fu_q[j] <= '0;
            for (int f = 0; f < NUM_FUS; f++) slot_q[f] <= '0;
        end else begin
            valid_q    <= valid_d;
            selected_q <= selected_d;
            free_q     <= free_d;
            clear_q    <= clear_d;
            clear_en_q <= clear_en_d;
            for (int j = 0; j < RS_ENTRIES; j++) fu_q[j] <= fu_d[j];
            for (int f = 0; f < NUM_FUS; f++) slot_q[f] <= slot_d[f];
        end
    end

    // Flatten the slots onto the issue ports.
    always_comb begin
        issue_valid = '0;
        issue_idx   = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            issue_valid[f]                = slot_q[f].valid;
            issue_idx[f*IDX_W +: IDX_W]   = slot_q[f].idx;
        end
    end

    assign selected_vec = selected_q;
    assign clear_lines  = clear_q;
    assign clear_en     = clear_en_q;
    assign free_vec     = free_q;

    // Allocating a row that is still live is an upstream bug.
    assert property (@(posedge clk) disable iff (rst) (alloc_en && !flush) |-> !valid_q[alloc_idx]);

`ifdef ISSUE_SELECT_PERF_EN
    logic [NUM_FUS-1:0][31:0] perf_issue_q, perf_stall_q;

    // Per-FU accepted-issue and blocked-candidate counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (slot_q[f].valid && issue_ready[f]) perf_issue_q[f] <= perf_issue_q[f] + 32'd1;
                if (|cand[f] && !slot_free[f])         perf_stall_q[f] <= perf_stall_q[f] + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios plus randomized traffic, all checked
// against an oldest-first reference model built on allocation sequence numbers.
module tb_issue_select;
  import issue_select_pkg::*;

  localparam int RS    = RS_ENTRIES;
  localparam int NF    = NUM_FUS;
  localparam int EXP_W = NF + NF*IDX_W + RS + 1 + RS*NF + RS;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, flush, alloc_en;
  logic [IDX_W-1:0] alloc_idx;
  logic [FU_W-1:0] alloc_fu;
  logic [RS-1:0] request_vec;
  logic [NF-1:0] issue_valid, issue_ready;
  logic [NF*IDX_W-1:0] issue_idx;
  logic [RS-1:0] selected_vec, free_vec;
  logic clear_en;
  logic [RS*NF-1:0] clear_lines;

  always #5 clk = ~clk;

  issue_select dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en),
    .alloc_idx(alloc_idx), .alloc_fu(alloc_fu), .request_vec(request_vec),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
    .selected_vec(selected_vec), .clear_en(clear_en), .clear_lines(clear_lines),
    .free_vec(free_vec)
  );

  // ---------------- reference model ----------------
  bit          m_valid [RS];
  int          m_fu    [RS];
  int unsigned m_stamp [RS];
  int unsigned stamp_ctr;
  bit          m_sv    [NF];
  int          m_sidx  [NF];
  int          alloc_cnt, free_cnt;

  logic [EXP_W-1:0] exp_q[$];
  int n_vec, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step(output logic [EXP_W-1:0] e);
    logic [NF-1:0] iv;
    logic [NF*IDX_W-1:0] ii;
    logic [RS-1:0] sel, fr;
    logic [RS*NF-1:0] cl;
    int win [NF];
    int best;
    iv = '0; ii = '0; sel = '0; fr = '0; cl = '0;
    if (rst) begin
      for (int j = 0; j < RS; j++) begin m_valid[j] = 0; m_fu[j] = 0; end
      for (int f = 0; f < NF; f++) begin m_sv[f] = 0; m_sidx[f] = 0; end
      alloc_cnt = 0;
      free_cnt  = 0;
    end else if (flush) begin
      for (int j = 0; j < RS; j++) begin
        if (m_valid[j]) fr[j] = 1'b1;
        m_valid[j] = 0;
      end
      for (int f = 0; f < NF; f++) m_sv[f] = 0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        win[f] = -1;
        if (!m_sv[f] || issue_ready[f]) begin
          best = -1;
          for (int j = 0; j < RS; j++) begin
            if (request_vec[j] && m_valid[j] && m_fu[j] == f &&
                (best < 0 || m_stamp[j] < m_stamp[best])) best = j;
          end
          win[f] = best;
          m_sv[f] = (best >= 0);
          if (best >= 0) m_sidx[f] = best;
        end
      end
      for (int f = 0; f < NF; f++) begin
        if (win[f] >= 0) begin
          sel[win[f]] = 1'b1;
          fr[win[f]]  = 1'b1;
          cl[f*RS + win[f]] = 1'b1;
          m_valid[win[f]] = 0;
        end
      end
      if (alloc_en) begin
        m_valid[alloc_idx] = 1;
        m_fu[alloc_idx]    = int'(alloc_fu);
        m_stamp[alloc_idx] = stamp_ctr;
        stamp_ctr++;
        alloc_cnt++;
      end
    end
    for (int f = 0; f < NF; f++) begin
      iv[f] = m_sv[f];
      if (m_sv[f]) ii[f*IDX_W +: IDX_W] = rs_idx_t'(m_sidx[f]);
    end
    e = {iv, ii, sel, |cl, cl, fr};
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all();
    logic [EXP_W-1:0] e;
    logic [NF-1:0] e_iv;
    logic [NF*IDX_W-1:0] e_ii, d_ii;
    logic [RS-1:0] e_sel, e_fr;
    logic e_cen;
    logic [RS*NF-1:0] e_cl;
    e = exp_q.pop_front();
    {e_iv, e_ii, e_sel, e_cen, e_cl, e_fr} = e;
    d_ii = '0;
    for (int f = 0; f < NF; f++) begin
      if (e_iv[f]) d_ii[f*IDX_W +: IDX_W] = issue_idx[f*IDX_W +: IDX_W];
    end
    check("issue_valid",  64'(issue_valid),  64'(e_iv));
    check("issue_idx",    64'(d_ii),         64'(e_ii));
    check("selected_vec", 64'(selected_vec), 64'(e_sel));
    check("clear_en",     64'(clear_en),     64'(e_cen));
    check("clear_lines",  64'(clear_lines),  64'(e_cl));
    check("free_vec",     64'(free_vec),     64'(e_fr));
    for (int j = 0; j < RS; j++) if (free_vec[j]) free_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [EXP_W-1:0] e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_alloc(input int row, input int fu);
    alloc_en  = 1'b1;
    alloc_idx = rs_idx_t'(row);
    alloc_fu  = fu_type_t'(fu);
    tick();
    alloc_en  = 1'b0;
  endtask

  function automatic logic [IDX_W-1:0] idx_of(input int f);
    return issue_idx[f*IDX_W +: IDX_W];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int free_rows[$];
    int live;
    n_vec = 0; n_bad = 0; stamp_ctr = 0; alloc_cnt = 0; free_cnt = 0;
    rst = 1'b1; flush = 1'b0; alloc_en = 1'b0; alloc_idx = '0; alloc_fu = '0;
    request_vec = '0; issue_ready = '1;
    #2;
    tick();
    tick();
    check("reset_valid", 64'(issue_valid), 64'h0);
    check("reset_free",  64'(free_vec),    64'h0);
    rst = 1'b0;

    // Oldest-first among one FU: 3, then 7, then 1.
    do_alloc(3, 0); do_alloc(7, 0); do_alloc(1, 0);
    request_vec = 16'h008A;
    tick(); check("s1_first",  64'(idx_of(0)), 64'd3);
    tick(); check("s1_second", 64'(idx_of(0)), 64'd7);
    tick(); check("s1_third",  64'(idx_of(0)), 64'd1);
    request_vec = '0;
    tick();

    // Two FUs granted in the same cycle.
    do_alloc(2, 0); do_alloc(5, 2);
    request_vec = 16'h0024;
    tick();
    check("s2_valid", 64'(issue_valid), 64'h5);
    check("s2_clear", 64'(clear_lines), 64'h0000_0020_0000_0004);
    check("s2_free",  64'(free_vec),    64'h0024);
    request_vec = '0;
    tick();

    // Back-pressure on FU1: row 9 held, row 4 waits.
    do_alloc(9, 1); do_alloc(4, 1);
    request_vec = (16'h1 << 9) | (16'h1 << 4);
    issue_ready = 4'b1101;
    tick();
    check("s3_load", 64'(idx_of(1)), 64'd9);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("s3_hold_idx",   64'(idx_of(1)),     64'd9);
      check("s3_hold_valid", 64'(issue_valid[1]), 64'h1);
    end
    issue_ready = '1;
    tick();
    check("s3_next", 64'(idx_of(1)), 64'd4);
    request_vec = '0;
    tick();

    // Flush with live rows and a busy slot.
    do_alloc(0, 0); do_alloc(6, 1); do_alloc(11, 2); do_alloc(12, 3);
    request_vec = 16'h1 << 12;
    issue_ready = 4'b0111;
    tick();
    request_vec = '0;
    flush = 1'b1;
    tick();
    check("flush_valid", 64'(issue_valid), 64'h0);
    check("flush_free",  64'(free_vec),    64'h0841);
    flush = 1'b0;
    request_vec = '1;
    issue_ready = '1;
    tick();
    check("post_flush_sel",   64'(selected_vec), 64'h0);
    check("post_flush_valid", 64'(issue_valid),  64'h0);
    request_vec = '0;

    // Reset mid-stream, then reuse row 0.
    do_alloc(5, 0); do_alloc(0, 0);
    request_vec = 16'h0021;
    issue_ready = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 64'(issue_valid),  64'h0);
    check("rst_mid_free",  64'(free_vec),     64'h0);
    check("rst_mid_sel",   64'(selected_vec), 64'h0);
    rst = 1'b0;
    request_vec = '0;
    issue_ready = '1;
    do_alloc(0, 0); do_alloc(5, 0);
    request_vec = 16'h0021;
    tick(); check("realloc_first",  64'(idx_of(0)), 64'd0);
    tick(); check("realloc_second", 64'(idx_of(0)), 64'd5);
    request_vec = '0;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 10000; c++) begin
      rst   = ($urandom_range(0, 1999) == 0);
      flush = ($urandom_range(0, 299) == 0);
      free_rows.delete();
      for (int j = 0; j < RS; j++) if (!m_valid[j]) free_rows.push_back(j);
      alloc_en = 1'b0;
      if (free_rows.size() > 0 && $urandom_range(0, 9) < 6) begin
        alloc_en  = 1'b1;
        alloc_idx = rs_idx_t'(free_rows[$urandom_range(0, free_rows.size() - 1)]);
        alloc_fu  = fu_type_t'($urandom_range(0, NF - 1));
      end
      request_vec = RS'($urandom());
      for (int f = 0; f < NF; f++) issue_ready[f] = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; request_vec = '0;
    tick();

    live = 0;
    for (int j = 0; j < RS; j++) if (m_valid[j]) live++;
    check("alloc_free_balance", 64'(alloc_cnt), 64'(free_cnt + live));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
